// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - samples a multiplexed seven-segment bus and rebuilds multi-digit frames
//
// Purpose: synchronizes {digit_en, seg_a..seg_g}, waits for STABLE_CYCLES identical
// samples, decodes the active digit's pattern to a 3-bit code and publishes a frame
// once every digit position has been captured.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   seg_a..seg_g segment lines, active-high, asynchronous to clk
//   digit_en     one-hot digit select, all-zero = blanking
//   cap_valid    one-cycle pulse per captured digit
//   cap_digit    index of captured digit (with cap_valid)
//   cap_code     decoded code of captured digit (with cap_valid)
//   value_out    last complete frame, digit i at [3i+2:3i]
//   frame_valid  one-cycle pulse when value_out updates
//   frame_err    frame in value_out contained an unknown pattern
//   onehot_err   one-cycle pulse when a stable digit_en was multi-hot

module seven_segment_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      seg_a,
  input  logic                      seg_b,
  input  logic                      seg_c,
  input  logic                      seg_d,
  input  logic                      seg_e,
  input  logic                      seg_f,
  input  logic                      seg_g,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      cap_valid,
  output logic [2:0]                cap_digit,
  output logic [2:0]                cap_code,
  output logic [3*NUM_DIGITS-1:0]   value_out,
  output logic                      frame_valid,
  output logic                      frame_err,
  output logic                      onehot_err
);

  localparam int W  = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {SEEK, WAIT, HELD} state_t;

  state_t                    state, state_next;
  logic [W-1:0]              raw, sync1, samp, samp_prev;
  logic [CW-1:0]             cnt;
  logic                      chg;
  logic                      capture;
  logic [NUM_DIGITS-1:0]     en;
  logic [6:0]                seg7;
  logic [3:0]                hot_cnt;
  logic [2:0]                hot_idx;
  logic [2:0]                code_now;
  logic                      bad_now;
  logic [NUM_DIGITS-1:0]     seen, seen_upd;
  logic                      frame_bad;
  logic [3*NUM_DIGITS-1:0]   slots, slots_upd;

  assign raw  = {digit_en, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
  assign en   = samp[W-1:7];
  assign seg7 = samp[6:0];
  assign chg  = (samp != samp_prev);

  // The counter looks at the value about to enter samp, so cnt equals the number
  // of consecutive cycles the current sample has been held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      samp      <= '0;
      samp_prev <= '0;
      cnt       <= '0;
    end else begin
      sync1     <= raw;
      samp      <= sync1;
      samp_prev <= samp;
      if (sync1 != samp)
        cnt <= CW'(1);
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEEK;
    else     state <= state_next;
  end

  // SEEK may also capture: with STABLE_CYCLES=2 the count completes while the
  // FSM is still returning from SEEK after the change.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      SEEK: begin
        if (cnt == CNT_MAX) begin
          capture    = 1'b1;
          state_next = HELD;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_MAX) begin
          capture    = 1'b1;
          state_next = HELD;
        end else if (chg) begin
          state_next = SEEK;
        end
      end
      HELD: begin
        if (chg) state_next = WAIT;
      end
      default: state_next = SEEK;
    endcase
  end

  always_comb begin
    hot_cnt = 4'd0;
    hot_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (en[i]) begin
        hot_cnt = hot_cnt + 4'd1;
        hot_idx = 3'(i);
      end
    end
  end

  always_comb begin
    bad_now = 1'b0;
    case (seg7)
      7'b1111110: code_now = 3'd0;
      7'b0110000: code_now = 3'd1;
      7'b1101101: code_now = 3'd2;
      7'b1111001: code_now = 3'd3;
      7'b1001111: code_now = 3'd4;
      default: begin
        code_now = 3'd7;
        bad_now  = 1'b1;
      end
    endcase
  end

  // Only used when en is one-hot, so OR-ing en marks exactly the captured slot.
  always_comb begin
    seen_upd  = seen | en;
    slots_upd = slots;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (en[i]) slots_upd[3*i +: 3] = code_now;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_valid   <= 1'b0;
      cap_digit   <= '0;
      cap_code    <= '0;
      value_out   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      onehot_err  <= 1'b0;
      seen        <= '0;
      frame_bad   <= 1'b0;
      slots       <= '0;
    end else begin
      cap_valid   <= 1'b0;
      frame_valid <= 1'b0;
      onehot_err  <= 1'b0;
      if (capture) begin
        if (hot_cnt > 4'd1) begin
          onehot_err <= 1'b1;
        end else if (hot_cnt == 4'd1) begin
          cap_valid <= 1'b1;
          cap_digit <= hot_idx;
          cap_code  <= code_now;
          slots     <= slots_upd;
          if (&seen_upd) begin
            value_out   <= slots_upd;
            frame_err   <= frame_bad | bad_now;
            frame_valid <= 1'b1;
            seen        <= '0;
            frame_bad   <= 1'b0;
          end else begin
            seen      <= seen_upd;
            frame_bad <= frame_bad | bad_now;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// tb/tb_seven_segment_reader.sv - self-checking bench for seven_segment_reader

module tb_seven_segment_reader;

  localparam int ND = 4;
  localparam int SC = 4;

  localparam logic [6:0] P0 = 7'b1111110;
  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] P2 = 7'b1101101;
  localparam logic [6:0] P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b1001111;
  localparam logic [6:0] PX = 7'b0000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic [ND-1:0] digit_en;
  logic cap_valid;
  logic [2:0] cap_digit, cap_code;
  logic [3*ND-1:0] value_out;
  logic frame_valid, frame_err, onehot_err;

  seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g),
    .digit_en(digit_en),
    .cap_valid(cap_valid), .cap_digit(cap_digit), .cap_code(cap_code),
    .value_out(value_out), .frame_valid(frame_valid), .frame_err(frame_err),
    .onehot_err(onehot_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ND-1:0] en;
    logic [6:0]    seg;
    int            n;
  } item_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cap_t = 0;
  int apply_t = 0;
  int oh_n = 0;
  item_t stim_q[$];
  logic [5:0]  cap_q[$];
  logic [12:0] frm_q[$];
  logic [11:0] last_val = '0;
  logic        last_err = 1'b0;

  logic [5:0]  exp_cap[$];
  logic [12:0] exp_frm[$];
  int          exp_oh;
  logic [ND-1:0] m_seen;
  logic          m_bad;
  logic [2:0]    m_slot [ND];

  always @(posedge clk) cyc++;

  // Observer: records DUT events and checks that value_out/frame_err only move with frame_valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (cap_valid) begin
        cap_q.push_back({cap_digit, cap_code});
        cap_t = cyc;
      end
      if (onehot_err) oh_n++;
      if (frame_valid) begin
        frm_q.push_back({frame_err, value_out});
        last_val = value_out;
        last_err = frame_err;
      end else begin
        vectors++;
        if (value_out !== last_val || frame_err !== last_err) begin
          miscompares++;
          $display("FAIL value_hold: got %h/%b expected %h/%b at cycle %0d",
                   value_out, frame_err, last_val, last_err, cyc);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    digit_en = '0;
    {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = 7'b0;
    repeat (3) @(negedge clk);
    stim_q.delete();
    cap_q.delete();
    frm_q.delete();
    oh_n = 0;
    last_val = '0;
    last_err = 1'b0;
    rst = 1'b0;
  endtask

  task automatic apply(input logic [ND-1:0] en, input logic [6:0] seg, input int n);
    item_t it;
    digit_en = en;
    {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg;
    apply_t = cyc;
    it.en = en;
    it.seg = seg;
    it.n = n;
    stim_q.push_back(it);
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    apply(4'b0001, s0, 10);
    apply(4'b0010, s1, 10);
    apply(4'b0100, s2, 10);
    apply(4'b1000, s3, 10);
    apply(4'b0000, 7'b0, 12);
  endtask

  function automatic logic [2:0] ref_decode(input logic [6:0] s);
    if (s == P0) return 3'd0;
    if (s == P1) return 3'd1;
    if (s == P2) return 3'd2;
    if (s == P3) return 3'd3;
    if (s == P4) return 3'd4;
    return 3'd7;
  endfunction

  // One run = one maximal stretch of identical input held for len cycles.
  function automatic void model_run(input logic [ND-1:0] en, input logic [6:0] seg, input int len);
    int k = 0;
    logic [2:0] c;
    logic [11:0] v;
    if (len < SC || en == '0) return;
    if ($countones(en) > 1) begin
      exp_oh++;
      return;
    end
    for (int i = 0; i < ND; i++) if (en[i]) k = i;
    c = ref_decode(seg);
    m_slot[k] = c;
    m_seen[k] = 1'b1;
    if (c == 3'd7) m_bad = 1'b1;
    exp_cap.push_back({3'(k), c});
    if (m_seen == '1) begin
      v = '0;
      for (int i = 0; i < ND; i++) v = v | (12'(m_slot[i]) << (3 * i));
      exp_frm.push_back({m_bad, v});
      m_seen = '0;
      m_bad = 1'b0;
    end
  endfunction

  function automatic void build_model();
    item_t cur;
    exp_cap.delete();
    exp_frm.delete();
    exp_oh = 0;
    m_seen = '0;
    m_bad = 1'b0;
    for (int i = 0; i < ND; i++) m_slot[i] = 3'd0;
    if (stim_q.size() == 0) return;
    cur = stim_q[0];
    for (int i = 1; i < stim_q.size(); i++) begin
      if (stim_q[i].en == cur.en && stim_q[i].seg == cur.seg) begin
        cur.n += stim_q[i].n;
      end else begin
        model_run(cur.en, cur.seg, cur.n);
        cur = stim_q[i];
      end
    end
    model_run(cur.en, cur.seg, cur.n);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    digit_en = '0;
    {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = 7'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cap_valid, cap_digit, cap_code, value_out, frame_valid, frame_err, onehot_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {cap_valid, cap_digit, cap_code, value_out, frame_valid, frame_err, onehot_err});
    end
    do_reset();
  endtask

  task automatic test_clean_scan();
    logic [5:0] want [4];
    want[0] = {3'd0, 3'd0};
    want[1] = {3'd1, 3'd1};
    want[2] = {3'd2, 3'd2};
    want[3] = {3'd3, 3'd4};
    do_reset();
    scan(P0, P1, P2, P4);
    vectors++;
    if (cap_q.size() !== 4) begin
      miscompares++;
      $display("FAIL clean_cap_count: got %0d expected 4", cap_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (cap_q[i] !== want[i]) begin
          miscompares++;
          $display("FAIL clean_cap_%0d: got %h expected %h", i, cap_q[i], want[i]);
        end
      end
    end
    vectors++;
    if (frm_q.size() !== 1 || frm_q[0] !== {1'b0, 12'h888}) begin
      miscompares++;
      $display("FAIL clean_frame: got count %0d value %h expected 1 frame 0888",
               frm_q.size(), (frm_q.size() > 0) ? frm_q[0] : 13'h0);
    end
  endtask

  task automatic test_glitch();
    int base;
    int t0;
    do_reset();
    apply(4'b0000, 7'b0, 10);
    base = cap_q.size();
    apply(4'b0010, P1, 3);
    apply(4'b0000, 7'b0, 10);
    vectors++;
    if (cap_q.size() !== base) begin
      miscompares++;
      $display("FAIL glitch_no_cap: got %0d captures expected %0d", cap_q.size(), base);
    end
    apply(4'b0001, P0, SC);
    t0 = apply_t;
    apply(4'b0000, 7'b0, 10);
    vectors++;
    if (cap_q.size() !== base + 1) begin
      miscompares++;
      $display("FAIL exact_hold_cap: got %0d captures expected %0d", cap_q.size(), base + 1);
    end
    vectors++;
    if (cap_t - t0 !== SC + 2) begin
      miscompares++;
      $display("FAIL cap_latency: got %0d expected %0d", cap_t - t0, SC + 2);
    end
  endtask

  task automatic test_unknown();
    do_reset();
    scan(P0, P1, PX, P4);
    vectors++;
    if (cap_q.size() !== 4 || cap_q[2] !== {3'd2, 3'd7}) begin
      miscompares++;
      $display("FAIL unknown_code: got %0d caps, d2 %h expected 4 caps, d2 17",
               cap_q.size(), (cap_q.size() > 2) ? cap_q[2] : 6'h0);
    end
    vectors++;
    if (frm_q.size() !== 1 || frm_q[0] !== {1'b1, 12'h9C8}) begin
      miscompares++;
      $display("FAIL unknown_frame: got %0d frames, %h expected 1 frame 19c8",
               frm_q.size(), (frm_q.size() > 0) ? frm_q[0] : 13'h0);
    end
    scan(P0, P1, P2, P4);
    vectors++;
    if (frm_q.size() !== 2 || frm_q[1] !== {1'b0, 12'h888}) begin
      miscompares++;
      $display("FAIL clean_after_bad: got %0d frames, %h expected 2 frames, last 0888",
               frm_q.size(), (frm_q.size() > 1) ? frm_q[1] : 13'h0);
    end
  endtask

  task automatic test_multihot();
    do_reset();
    apply(4'b0110, P0, 10);
    apply(4'b0000, 7'b0, 10);
    apply(4'b0000, P3, 10);
    apply(4'b0000, 7'b0, 10);
    vectors++;
    if (oh_n !== 1 || cap_q.size() !== 0) begin
      miscompares++;
      $display("FAIL multihot: got %0d onehot_err %0d caps expected 1 and 0", oh_n, cap_q.size());
    end
    apply(4'b0001, P0, 10);
    apply(4'b1000, P4, 10);
    apply(4'b0000, 7'b0, 10);
    vectors++;
    if (frm_q.size() !== 0) begin
      miscompares++;
      $display("FAIL multihot_seen: got %0d frames expected 0", frm_q.size());
    end
    apply(4'b0010, P1, 10);
    apply(4'b0100, P2, 10);
    apply(4'b0000, 7'b0, 10);
    vectors++;
    if (frm_q.size() !== 1 || frm_q[0] !== {1'b0, 12'h888}) begin
      miscompares++;
      $display("FAIL multihot_frame: got %0d frames, %h expected 1 frame 0888",
               frm_q.size(), (frm_q.size() > 0) ? frm_q[0] : 13'h0);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    apply(4'b0001, P0, 10);
    apply(4'b0010, P1, 10);
    apply(4'b0000, 7'b0, 10);
    vectors++;
    if (cap_q.size() !== 2) begin
      miscompares++;
      $display("FAIL midframe_caps: got %0d expected 2", cap_q.size());
    end
    do_reset();
    apply(4'b0001, P0, 10);
    apply(4'b0010, P1, 10);
    apply(4'b0100, P2, 10);
    apply(4'b0000, 7'b0, 10);
    vectors++;
    if (frm_q.size() !== 0 || value_out !== '0) begin
      miscompares++;
      $display("FAIL midframe_partial: got %0d frames value %h expected 0 frames value 000",
               frm_q.size(), value_out);
    end
    apply(4'b1000, P4, 10);
    apply(4'b0000, 7'b0, 10);
    vectors++;
    if (frm_q.size() !== 1 || value_out !== 12'h888) begin
      miscompares++;
      $display("FAIL midframe_complete: got %0d frames value %h expected 1 frame value 888",
               frm_q.size(), value_out);
    end
  endtask

  task automatic test_recapture();
    do_reset();
    apply(4'b0001, P0, 10);
    apply(4'b0001, P3, 10);
    scan(P3, P1, P2, P4);
    vectors++;
    if (frm_q.size() !== 1 || frm_q[0] !== {1'b0, 12'h88B}) begin
      miscompares++;
      $display("FAIL recapture: got %0d frames, %h expected 1 frame 088b",
               frm_q.size(), (frm_q.size() > 0) ? frm_q[0] : 13'h0);
    end
  endtask

  task automatic test_random();
    logic [6:0] known [5];
    logic [ND-1:0] en;
    logic [6:0] seg;
    int r;
    known[0] = P0; known[1] = P1; known[2] = P2; known[3] = P3; known[4] = P4;
    do_reset();
    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        en = '0;
      end else if (r == 1) begin
        en = ND'($urandom_range(3, 15));
        while ($countones(en) < 2) en = ND'($urandom_range(3, 15));
      end else begin
        en = ND'(1) << $urandom_range(0, ND - 1);
      end
      if ($urandom_range(0, 3) != 0) seg = known[$urandom_range(0, 4)];
      else seg = 7'($urandom);
      apply(en, seg, $urandom_range(1, 8));
    end
    apply(4'b0000, 7'b0, 12);
    build_model();
    vectors++;
    if (oh_n !== exp_oh) begin
      miscompares++;
      $display("FAIL rand_onehot: got %0d expected %0d", oh_n, exp_oh);
    end
    vectors++;
    if (cap_q.size() !== exp_cap.size()) begin
      miscompares++;
      $display("FAIL rand_cap_count: got %0d expected %0d", cap_q.size(), exp_cap.size());
    end else begin
      for (int i = 0; i < exp_cap.size(); i++) begin
        vectors++;
        if (cap_q[i] !== exp_cap[i]) begin
          miscompares++;
          $display("FAIL rand_cap_%0d: got %h expected %h", i, cap_q[i], exp_cap[i]);
        end
      end
    end
    vectors++;
    if (frm_q.size() !== exp_frm.size()) begin
      miscompares++;
      $display("FAIL rand_frame_count: got %0d expected %0d", frm_q.size(), exp_frm.size());
    end else begin
      for (int i = 0; i < exp_frm.size(); i++) begin
        vectors++;
        if (frm_q[i] !== exp_frm[i]) begin
          miscompares++;
          $display("FAIL rand_frame_%0d: got %h expected %h", i, frm_q[i], exp_frm[i]);
        end
      end
    end
  endtask

  initial begin
    digit_en = '0;
    {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = 7'b0;
    test_reset();
    test_clean_scan();
    test_glitch();
    test_unknown();
    test_multihot();
    test_reset_midframe();
    test_recapture();
    test_random();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end of run expected finish within 2000000 time units");
    $fatal(1);
  end

endmodule

// File: doc/seven_segment_reader.md
Name: seven_segment_reader

Overview:
Receive-side counterpart to the team's 3-bit-code-to-segment encoder. It samples an external, time-multiplexed seven-segment bus (per-digit enables plus segments a..g) and converts each stable segment pattern back to its 3-bit code. When every digit has been captured, it publishes one coherent multi-digit frame. It is used for loopback self-test of the display path and for reading display-driven peripherals.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
STABLE_CYCLES, 4, consecutive identical synchronized samples required before a capture (2..255).

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
seg_a..seg_g  input  1 each  segment lines, active-high, bit order {a,b,c,d,e,f,g}; asynchronous to clk.
digit_en  input  NUM_DIGITS  one-hot, active-high digit select; all-zero means blanking.
cap_valid  output  1  single-cycle pulse; one digit captured.
cap_digit  output  3  index of the captured digit; valid while cap_valid is high.
cap_code  output  3  decoded code of the captured digit; valid while cap_valid is high.
value_out  output  3*NUM_DIGITS  last complete frame; digit i occupies [3i+2:3i].
frame_valid  output  1  single-cycle pulse; value_out was updated this cycle.
frame_err  output  1  high when the frame in value_out contains an unknown pattern; holds until the next frame.
onehot_err  output  1  single-cycle pulse; a stable digit_en had more than one bit set.

Behaviour:
- Reset: all outputs 0; sync flops, stability counter, per-digit seen mask and capture registers are cleared; FSM goes to SEEK. Reset mid-frame discards any partial frame.
- Input sync: {digit_en, seg_a..seg_g} pass through two flop stages. All further logic uses the synchronized sample S.
- Stability counter: compares S with the previous S each cycle. On any difference it loads 1. Otherwise it increments, saturating at STABLE_CYCLES.
- FSM:
  - SEEK -> WAIT on any S.
  - WAIT -> SEEK on an S change.
  - WAIT -> HELD when the counter reaches STABLE_CYCLES; the capture action fires in that same cycle.
  - HELD -> WAIT on an S change. No repeat capture while the sample stays constant.
- Capture action, with registered outputs visible on the next cycle:
  - digit_en all-zero: no capture, no error.
  - digit_en multi-hot: onehot_err pulse; no capture.
  - digit_en one-hot at index k: cap_valid=1, cap_digit=k. Decode:
    - 1111110 -> 0
    - 0110000 -> 1
    - 1101101 -> 2
    - 1111001 -> 3
    - 1001111 -> 4 (the encoder's default glyph)
    - any other pattern -> 7, and frame_bad is set.
  - Write the code into slot k and set seen[k].
- Minimum latency from the input edge to cap_valid: STABLE_CYCLES+2 cycles.
- Recapture of a digit already in seen before the frame completes: the slot is overwritten, with no error.
- Frame completion:
  - When the seen mask (including the current capture) becomes all-ones, value_out is loaded with all slots in the next cycle. This includes the digit captured in the completing cycle.
  - In that cycle frame_valid=1 and frame_err=frame_bad, including the current capture's status.
  - seen and frame_bad are then cleared. The next capture starts the new frame.
- value_out and frame_err change only with frame_valid.
- A change in the segments alone (digit_en unchanged) counts as a sample change and restarts the stability count.

Test Plan:
- Clean scan, NUM_DIGITS=4, STABLE_CYCLES=4, each digit held 10 cycles: d0=1111110, d1=0110000, d2=1101101, d3=1001111 -> four cap_valid pulses with codes 0,1,2,4, then one frame_valid with value_out=12'h888 and frame_err=0.
- Glitch: d1 pattern held 3 cycles, then changed -> no cap_valid. A pattern held for exactly 4 synchronized cycles -> exactly one cap_valid, 6 cycles after the input edge.
- Unknown pattern 0000001 on d2 within a full scan -> cap_code=7 and frame_valid with frame_err=1. The next clean scan -> frame_err=0.
- digit_en=4'b0110 stable for 10 cycles -> one onehot_err pulse, no cap_valid, seen unchanged. digit_en=0 -> no pulses at all.
- rst asserted after d0 and d1 are captured, then a full scan -> value_out stays 0 until the first post-reset frame. frame_valid fires only after all four digits are captured again.
- Repeated d0 (codes 0 then 3) before d1..d3 -> the frame reports code 3 for d0; exactly one frame_valid.
